// File: rtl/compute_sequencer.sv
// compute_sequencer: job controller for a MUL_SIZE x MUL_SIZE systolic MAC array.
// It primes activations, counts rows per tile, stalls on a late weight tile and
// swaps weight buffers as a diagonal wavefront with one select bit per cell.
// Optional feature macro: COMPUTE_PERF_CNT_EN adds the stall_cycles_o counter.
module compute_sequencer #(
    parameter int MUL_SIZE = 32,
    parameter int DIM_W    = 9,
    parameter int TILE_W   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [DIM_W-1:0]             h_dim_i,
    input  logic [TILE_W-1:0]            n_tiles_i,
    input  logic                         weights_rdy_i,
    output logic [MUL_SIZE*MUL_SIZE-1:0] weight_sel_o,
    output logic                         weight_consumed_o,
    output logic                         load_act_o,
    output logic                         mac_en_o,
    output logic                         stall_o,
    output logic                         tile_done_o,
    output logic                         busy_o,
    output logic                         done_o
`ifdef COMPUTE_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles_o
`endif
);

    localparam int NCELL     = MUL_SIZE * MUL_SIZE;
    localparam int WAVE_LAST = 2 * MUL_SIZE - 2;
    localparam int WAVE_W    = $clog2(2 * MUL_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_COMPUTE, S_SWAP, S_STALL, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NCELL-1:0]    sel_q, sel_d;
    logic [DIM_W-1:0]    row_q, row_d;
    logic [DIM_W-1:0]    h_q, h_d;
    logic [TILE_W-1:0]   tiles_q, tiles_d;
    logic [WAVE_W-1:0]   wave_q, wave_d;
    logic                prime_q, prime_d;
    logic                pending_q, pending_d;
    logic                consumed_q, consumed_d;
    logic                load_q, load_d;
    logic                mac_q, mac_d;
    logic                stall_q, stall_d;
    logic                tdone_q, tdone_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                toggle;
    logic                last_row;

    // Cells on anti-diagonal k (row + col == k) flip together in wave cycle k.
    function automatic logic [NCELL-1:0] diag_mask(input logic [WAVE_W-1:0] k);
        logic [NCELL-1:0] m;
        m = '0;
        for (int r = 0; r < MUL_SIZE; r++) begin
            for (int c = 0; c < MUL_SIZE; c++) begin
                m[r*MUL_SIZE+c] = ((r + c) == int'(k));
            end
        end
        return m;
    endfunction

    assign last_row = (row_q == h_q - DIM_W'(1));

    // Next-state logic plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        row_d      = row_q;
        h_d        = h_q;
        tiles_d    = tiles_q;
        wave_d     = wave_q;
        prime_d    = prime_q;
        pending_d  = pending_q | start_i;
        consumed_d = 1'b0;
        tdone_d    = 1'b0;
        toggle     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((start_i | pending_q) & weights_rdy_i) begin
                    pending_d = 1'b0;
                    h_d       = (h_dim_i == '0) ? DIM_W'(1) : h_dim_i;
                    tiles_d   = n_tiles_i;
                    row_d     = '0;
                    wave_d    = '0;
                    if (n_tiles_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // Array is idle, so the whole buffer flips at once.
                        sel_d      = ~sel_q;
                        consumed_d = 1'b1;
                        prime_d    = 1'b0;
                        state_d    = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                if (prime_q) begin
                    state_d = S_COMPUTE;
                    row_d   = '0;
                end else begin
                    prime_d = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (last_row) begin
                    tdone_d = 1'b1;
                    if (tiles_q == TILE_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        tiles_d = tiles_q - TILE_W'(1);
                        row_d   = '0;
                        if (weights_rdy_i) begin
                            consumed_d = 1'b1;
                            wave_d     = '0;
                            toggle     = 1'b1;
                            state_d    = S_SWAP;
                        end else begin
                            state_d = S_STALL;
                        end
                    end
                end else begin
                    row_d = row_q + DIM_W'(1);
                end
            end
            S_STALL: begin
                if (weights_rdy_i) begin
                    consumed_d = 1'b1;
                    wave_d     = '0;
                    row_d      = '0;
                    toggle     = 1'b1;
                    state_d    = S_SWAP;
                end
            end
            S_SWAP: begin
                // The last row of a short tile waits for the wave to finish.
                if (!last_row) row_d = row_q + DIM_W'(1);
                if (wave_q == WAVE_W'(WAVE_LAST)) begin
                    state_d = S_COMPUTE;
                end else begin
                    wave_d = wave_q + WAVE_W'(1);
                    toggle = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (toggle) sel_d = sel_q ^ diag_mask(wave_d);

        busy_d  = state_d inside {S_PRIME, S_COMPUTE, S_SWAP, S_STALL};
        load_d  = state_d inside {S_PRIME, S_COMPUTE, S_SWAP};
        mac_d   = (state_d == S_COMPUTE) |
                  ((state_d == S_SWAP) & (row_d != h_d - DIM_W'(1)));
        stall_d = ~mac_d;
        done_d  = (state_d == S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            row_q      <= '0;
            h_q        <= '0;
            tiles_q    <= '0;
            wave_q     <= '0;
            prime_q    <= 1'b0;
            pending_q  <= 1'b0;
            consumed_q <= 1'b0;
            load_q     <= 1'b0;
            mac_q      <= 1'b0;
            stall_q    <= 1'b1;
            tdone_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            row_q      <= row_d;
            h_q        <= h_d;
            tiles_q    <= tiles_d;
            wave_q     <= wave_d;
            prime_q    <= prime_d;
            pending_q  <= pending_d;
            consumed_q <= consumed_d;
            load_q     <= load_d;
            mac_q      <= mac_d;
            stall_q    <= stall_d;
            tdone_q    <= tdone_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign weight_sel_o      = sel_q;
    assign weight_consumed_o = consumed_q;
    assign load_act_o        = load_q;
    assign mac_en_o          = mac_q;
    assign stall_o           = stall_q;
    assign tile_done_o       = tdone_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;

`ifdef COMPUTE_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Count frozen busy cycles outside priming; cleared when a job is accepted.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
            perf_d = '0;
        end else if (busy_d & ~mac_d & (state_d != S_PRIME)) begin
            perf_d = sat_inc(perf_q);
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign stall_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_compute_sequencer.sv
// Scoreboard bench for compute_sequencer (MUL_SIZE=4). The driver expands each
// job into per-cycle expectations from the tile/wave rules and queues them;
// a monitor compares every cycle's outputs against the queue head.
`timescale 1ns/1ps
module tb_compute_sequencer;
    localparam int M      = 4;
    localparam int DIM_W  = 9;
    localparam int TILE_W = 8;
    localparam int NB     = M * M;
    localparam int WAVE   = 2 * M - 1;

    logic              clk_i = 1'b0;
    logic              rst_i, start_i, weights_rdy_i;
    logic [DIM_W-1:0]  h_dim_i;
    logic [TILE_W-1:0] n_tiles_i;
    logic [NB-1:0]     weight_sel_o;
    logic weight_consumed_o, load_act_o, mac_en_o, stall_o, tile_done_o, busy_o, done_o;
`ifdef COMPUTE_PERF_CNT_EN
    logic [31:0]       stall_cycles_o;
`endif

    compute_sequencer #(.MUL_SIZE(M), .DIM_W(DIM_W), .TILE_W(TILE_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .h_dim_i(h_dim_i),
        .n_tiles_i(n_tiles_i), .weights_rdy_i(weights_rdy_i),
        .weight_sel_o(weight_sel_o), .weight_consumed_o(weight_consumed_o),
        .load_act_o(load_act_o), .mac_en_o(mac_en_o), .stall_o(stall_o),
        .tile_done_o(tile_done_o), .busy_o(busy_o), .done_o(done_o)
`ifdef COMPUTE_PERF_CNT_EN
        , .stall_cycles_o(stall_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [NB-1:0] sel;
        logic          cons, load, mac, stall, tdone, busy, done;
        logic          chk_perf;
        logic [31:0]   perf;
        logic [63:0]   tag;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0, failures = 0;
    logic [NB-1:0]     sel_m;
    int                stl[4];
    int                lim = -1, emitted = 0;
    bit                aborted = 0, hn_fix = 0;
    logic [DIM_W-1:0]  h_drv;
    logic [TILE_W-1:0] n_drv;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t mk(input logic [NB-1:0] s, input logic cons, input logic load,
                                input logic mac, input logic tdone, input logic busy,
                                input logic done, input logic [63:0] tag);
        exp_t e;
        e.sel = s; e.cons = cons; e.load = load; e.mac = mac; e.stall = ~mac;
        e.tdone = tdone; e.busy = busy; e.done = done;
        e.chk_perf = 1'b0; e.perf = '0; e.tag = tag;
        return e;
    endfunction

    // Cells already flipped once wave cycle k has been shown: all with r+c <= k.
    function automatic logic [NB-1:0] wave_upto(input int k);
        logic [NB-1:0] m;
        m = '0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                if (r + c <= k) m[r*M+c] = 1'b1;
        return m;
    endfunction

    function automatic exp_t with_perf(input exp_t e, input int p);
        exp_t x;
        x = e; x.chk_perf = 1'b1; x.perf = p;
        return x;
    endfunction

    // Drive inputs for the next clock edge and queue the outputs expected after it.
    task automatic step(input logic st, input logic rdy, input logic rst, input exp_t e);
        if (aborted) return;
        if (lim >= 0 && emitted == lim) begin aborted = 1; return; end
        @(negedge clk_i);
        rst_i = rst; start_i = st; weights_rdy_i = rdy;
        h_dim_i   = hn_fix ? h_drv : DIM_W'($urandom);
        n_tiles_i = hn_fix ? n_drv : TILE_W'($urandom);
        sb.push_back(e);
        emitted++;
    endtask

    task automatic run_job(input int h, input int n, input int pre, input bit via_pend,
                           input bit start_mid);
        int hh, srows, perf, d;
        logic acc_start;
        logic [NB-1:0] base;
        hh = (h == 0) ? 1 : h;
        srows = (hh - 1 < WAVE) ? hh - 1 : WAVE;
        perf = 0;
        acc_start = (pre == 0) && !via_pend;
        for (int i = 0; i < pre; i++) step(i == 0, 1'b0, 1'b0, mk(sel_m,0,0,0,0,0,0,"pending"));
        h_drv = h[DIM_W-1:0]; n_drv = n[TILE_W-1:0]; hn_fix = 1;
        if (n == 0) begin
            step(acc_start, 1'b1, 1'b0, with_perf(mk(sel_m,0,0,0,0,0,1,"done0"), 0));
            hn_fix = 0;
            step(1'b0, rb(), 1'b0, with_perf(mk(sel_m,0,0,0,0,0,0,"idle0"), 0));
            return;
        end
        sel_m = ~sel_m;
        step(acc_start, 1'b1, 1'b0, mk(sel_m,1,1,0,0,1,0,"prime1"));
        hn_fix = 0;
        step(start_mid, rb(), 1'b0, mk(sel_m,0,1,0,0,1,0,"prime2"));
        for (int t = 0; t < n; t++) begin
            for (int r = 0; r < ((t == 0) ? hh : hh - srows); r++)
                step(1'b0, rb(), 1'b0, mk(sel_m,0,1,1,0,1,0,"compute"));
            if (t == n - 1) begin
                step(1'b0, rb(), 1'b0, with_perf(mk(sel_m,0,0,0,1,0,1,"done"), perf));
                step(1'b0, rb(), 1'b0, with_perf(mk(sel_m,0,0,0,0,0,0,"idle"), perf));
            end else begin
                d = stl[t];
                for (int s = 0; s < d; s++) step(1'b0, 1'b0, 1'b0, mk(sel_m,0,0,0,s == 0,1,0,"stall"));
                perf += d;
                base = sel_m;
                for (int k = 0; k < WAVE; k++) begin
                    step(1'b0, (k == 0) ? 1'b1 : rb(), 1'b0,
                         mk(base ^ wave_upto(k), k == 0, 1, k < srows, (k == 0) && (d == 0), 1, 0, "swap"));
                    if (k >= srows) perf++;
                end
                sel_m = ~base;
            end
        end
    endtask

    // Monitor: compare every cycle's outputs with the queued expectation.
    initial begin
        exp_t e;
        logic [NB+6:0] act, req;
        forever begin
            @(posedge clk_i); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {weight_sel_o, weight_consumed_o, load_act_o, mac_en_o, stall_o,
                       tile_done_o, busy_o, done_o};
                req = {e.sel, e.cons, e.load, e.mac, e.stall, e.tdone, e.busy, e.done};
                checks++;
                if (act !== req) begin
                    failures++;
                    $display("FAIL %s outputs actual=%h required=%h (sel,cons,load,mac,stall,tdone,busy,done)",
                             e.tag, act, req);
                end
`ifdef COMPUTE_PERF_CNT_EN
                if (e.chk_perf) begin
                    checks++;
                    if (stall_cycles_o !== e.perf) begin
                        failures++;
                        $display("FAIL %s stall_cycles actual=%0d required=%0d", e.tag, stall_cycles_o, e.perf);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit pend;
        rst_i = 1'b1; start_i = 1'b0; weights_rdy_i = 1'b0; h_dim_i = '0; n_tiles_i = '0;
        sel_m = '0;
        repeat (2) step(1'b1, 1'b1, 1'b1, with_perf(mk('0,0,0,0,0,0,0,"reset"), 0));
        step(1'b0, 1'b1, 1'b0, mk(sel_m,0,0,0,0,0,0,"idle"));
        // Single tile, then two tiles back to back, then a late weight tile.
        stl = '{0, 0, 0, 0};
        run_job(8, 1, 0, 0, 0);
        run_job(10, 2, 0, 0, 0);
        stl = '{5, 0, 0, 0};
        run_job(6, 2, 0, 0, 0);
        // Short tile that outruns the swap wavefront.
        stl = '{0, 0, 0, 0};
        run_job(3, 2, 0, 0, 0);
        // Start while weights are not ready, then an empty job.
        run_job(5, 1, 4, 0, 0);
        run_job(7, 0, 3, 0, 0);
        // Start during a busy job is held and accepted after DONE.
        stl = '{2, 1, 0, 0};
        run_job(4, 1, 0, 0, 1);
        run_job(2, 3, 0, 1, 0);
        // Reset in the middle of a swap wave with start asserted.
        stl = '{0, 0, 0, 0};
        lim = emitted + 14;
        run_job(8, 2, 0, 0, 0);
        lim = -1; aborted = 0; sel_m = '0;
        step(1'b1, 1'b1, 1'b1, with_perf(mk('0,0,0,0,0,0,0,"rstmid"), 0));
        repeat (3) step(1'b0, 1'b1, 1'b0, mk(sel_m,0,0,0,0,0,0,"postrst"));
        // Randomized jobs.
        pend = 0;
        for (int j = 0; j < 16; j++) begin
            int h, n, pre;
            bit mid;
            h = $urandom_range(0, 12);
            n = $urandom_range(0, 3);
            pre = pend ? 0 : $urandom_range(0, 3);
            mid = ($urandom_range(0, 3) == 0) && (n != 0);
            for (int t = 0; t < 4; t++) stl[t] = $urandom_range(0, 4);
            run_job(h, n, pre, pend, mid);
            pend = mid;
            if (!pend) repeat ($urandom_range(0, 2)) step(1'b0, rb(), 1'b0, mk(sel_m,0,0,0,0,0,0,"gap"));
        end
        step(1'b0, 1'b0, 1'b0, mk(sel_m,0,0,0,0,0,0,"tail"));
        @(posedge clk_i); #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/compute_sequencer.md
Name: compute_sequencer

Overview:
Parametrised controller for the MUL_SIZE x MUL_SIZE systolic MAC array. It sequences a multi-tile job: activation priming, per-tile row counting, and stalls when the next weight tile is late. Weight buffer swaps run as a diagonal wavefront, with one select bit per cell. It sits between the weight loader (double-buffered weight FIFO) and the MAC array / activation feeder.

Parameters:
MUL_SIZE, 32, array rows = columns; weight_sel_o is MUL_SIZE*MUL_SIZE bits
DIM_W, 9, width of h_dim_i (rows per tile)
TILE_W, 8, width of n_tiles_i (weight tiles per job)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  job request, latched into a pending flag until accepted
h_dim_i  in  DIM_W  activation rows per tile; sampled at accept; 0 treated as 1
n_tiles_i  in  TILE_W  weight tiles in job; sampled at accept
weights_rdy_i  in  1  shadow weight buffer holds the next tile
weight_sel_o  out  MUL_SIZE*MUL_SIZE  per-cell buffer select, bit r*MUL_SIZE+c = cell(row r, col c)
weight_consumed_o  out  1  1-cycle pulse: shadow buffer taken, loader may refill
load_act_o  out  1  activation feeder enable
mac_en_o  out  1  MAC array compute enable
stall_o  out  1  array frozen (inverse of mac_en_o except in IDLE/DONE, where it is 1)
tile_done_o  out  1  1-cycle pulse after the last row of each tile
busy_o  out  1  job in progress
done_o  out  1  1-cycle pulse at job end

Behaviour:
- All outputs are registered.
- Reset (any state, including mid-job): state IDLE; weight_sel_o=0; row/tile/wave counters=0; pending=0.
- Reset output values: weight_consumed_o=0, load_act_o=0, mac_en_o=0, tile_done_o=0, busy_o=0, done_o=0, stall_o=1.
- States: IDLE, PRIME, COMPUTE, SWAP, STALL, DONE.
- IDLE: stall_o=1, all other controls 0.
  - Accept when (start_i | pending) & weights_rdy_i: latch h_dim and n_tiles; invert every weight_sel_o bit (array idle, full swap); pulse weight_consumed_o; busy_o=1; go PRIME.
  - Accept with n_tiles_i=0: no swap and no consume; go DONE.
  - start_i with weights_rdy_i=0: set pending.
- PRIME: load_act_o=1, mac_en_o=0, exactly 2 cycles, then COMPUTE with row_cntr=0. The first mac_en_o=1 is the 3rd cycle after the accept edge.
- COMPUTE: load_act_o=1, mac_en_o=1; row_cntr increments each cycle. At row_cntr==h_dim-1:
  - pulse tile_done_o next cycle;
  - tiles_left==1: go DONE;
  - else weights_rdy_i=1: pulse weight_consumed_o, wave k=0, row_cntr=0, go SWAP;
  - else go STALL.
  - weights_rdy_i deasserting mid-tile has no effect.
- STALL: mac_en_o=0, load_act_o=0, stall_o=1. When weights_rdy_i=1: pulse weight_consumed_o, k=0, row_cntr=0, go SWAP.
- SWAP: the wavefront runs 2*MUL_SIZE-1 cycles. In wave cycle k, every cell with r+c==k toggles its select bit.
  - MAC and activations keep running for the new tile; row_cntr counts.
  - After k==2*MUL_SIZE-2, go COMPUTE with row_cntr preserved.
  - If row_cntr reaches h_dim-1 before the wave ends (short tile), row_cntr holds and mac_en_o=0, stall_o=1 until the wave completes. The tile-end handling from COMPUTE then applies on the cycle after the last wave cycle.
- Total toggles per swap = MUL_SIZE*MUL_SIZE; each cell toggles exactly once.
- DONE: done_o=1 for 1 cycle, busy_o=0, then IDLE. weight_sel_o is retained (the next job starts from the other buffer).
- Simultaneous start_i during a busy job: sets pending; the new job is accepted in IDLE after DONE.
- Counter widths: row_cntr is DIM_W bits, tiles_left is TILE_W bits, wave counter is clog2(2*MUL_SIZE) bits. No wrap-around is possible within legal inputs.

Optional Feature:
COMPUTE_PERF_CNT_EN
- Defined: adds output stall_cycles_o (32 bits). It counts cycles with busy_o=1 & mac_en_o=0 outside PRIME, i.e. STALL plus short-tile SWAP hold. It saturates at all-ones, clears on job accept and on reset, and holds after DONE.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. MUL_SIZE=4. Assert rst_i mid-SWAP -> next cycle IDLE, weight_sel_o=0, stall_o=1, other outputs 0; start_i, pending and partial wave are discarded.
2. h_dim=8, n_tiles=1, weights_rdy=1, start pulse:
   - weight_sel_o=16'hFFFF one cycle after accept; PRIME for 2 cycles;
   - mac_en_o=1 for exactly 8 cycles; one tile_done_o;
   - done_o 1 cycle, busy_o falls; one weight_consumed_o.
3. h_dim=10, n_tiles=2, weights_rdy held 1:
   - mac_en_o continuous for 20 cycles; SWAP lasts 7 cycles;
   - bit 0 toggles in wave cycle 0, bits 1 and 4 in cycle 1, bit 15 in cycle 6;
   - 2 tile_done_o, 2 weight_consumed_o.
4. n_tiles=2, weights_rdy low for 5 cycles at end of tile 0 -> STALL for 5 cycles with mac_en_o=0, then SWAP; total mac_en_o cycles = 2*h_dim. With COMPUTE_PERF_CNT_EN, stall_cycles_o=5.
5. h_dim=3, n_tiles=2 (short tile) -> in SWAP, mac_en_o=1 for 2 cycles then 0 for 5 cycles (row_cntr held at 2); remaining row in COMPUTE; total mac_en_o cycles=6; stall_cycles_o=5.
6. start_i with weights_rdy=0 for 4 cycles, then weights_rdy=1 -> accepted on the rdy cycle via pending; n_tiles=0 job -> done_o next cycle with no weight_sel_o change and no weight_consumed_o.
